// File: rtl/direction_ctrl.sv
// Snake direction controller: debounced buttons, move-tick pacing, optional pause.
// Optional pause feature compiled in with `define DIRECTION_PAUSE_EN.
module direction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_CYCLES     = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_top,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_pause,
  input  logic       calc_done,
  output logic [1:0] direction,
  output logic       move_tick,
  output logic       paused
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TW-1:0] TMAX = TW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_TOP   = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

`ifdef DIRECTION_PAUSE_EN
  localparam int NB = 5;
  logic [NB-1:0] raw;
  assign raw = {btn_pause, btn_down, btn_right, btn_top, btn_left};
`else
  localparam int NB = 4;
  logic [NB-1:0] raw;
  logic          unused_pause;
  assign raw          = {btn_down, btn_right, btn_top, btn_left};
  assign unused_pause = btn_pause;
`endif

  logic [NB-1:0] s1_q;
  logic [NB-1:0] s2_q;
  logic [NB-1:0] deb_q;
  logic [NB-1:0] dly_q;
  logic [DW-1:0] cnt_q [NB];
  logic [NB-1:0] press;

  // Counter runs only while the synced level differs from the accepted one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      deb_q <= '0;
      dly_q <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      dly_q <= deb_q;
      for (int i = 0; i < NB; i++) begin
        if (s2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DMAX) begin
          deb_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign press = deb_q & ~dly_q;

  logic       sel_vld;
  logic [1:0] sel_dir;

  always_comb begin
    sel_vld = 1'b1;
    sel_dir = DIR_LEFT;
    if (press[0]) begin
      sel_dir = DIR_LEFT;
    end else if (press[1]) begin
      sel_dir = DIR_TOP;
    end else if (press[2]) begin
      sel_dir = DIR_RIGHT;
    end else if (press[3]) begin
      sel_dir = DIR_DOWN;
    end else begin
      sel_vld = 1'b0;
    end
  end

  logic [1:0] dir_q;
  logic [1:0] dir_d;
  logic [1:0] req_dir_q;
  logic [1:0] req_dir_d;

  // Opposite directions differ only in bit 1.
  always_comb begin
    req_dir_d = req_dir_q;
    if (sel_vld && (sel_dir != (dir_q ^ 2'd2))) begin
      req_dir_d = sel_dir;
    end
  end

  logic pause_hold;

`ifdef DIRECTION_PAUSE_EN
  logic paused_q;
  logic paused_d;

  always_comb begin
    paused_d = paused_q;
    if (press[4]) begin
      paused_d = ~paused_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paused_q <= 1'b0;
    end else begin
      paused_q <= paused_d;
    end
  end

  assign pause_hold = paused_q;
  assign paused     = paused_q;
`else
  assign pause_hold = 1'b0;
  assign paused     = 1'b0;
`endif

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic          tick_q;
  logic          tick_d;
  logic          sat;

  assign sat = (tcnt_q == TMAX);

  // A saturated WAIT fires straight away on calc_done.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    tick_d  = 1'b0;
    dir_d   = dir_q;
    if (!pause_hold) begin
      unique case (state_q)
        S_RUN: begin
          if (sat) begin
            tick_d  = 1'b1;
            dir_d   = req_dir_q;
            tcnt_d  = '0;
            state_d = S_WAIT;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_WAIT: begin
          if (calc_done && sat) begin
            tick_d  = 1'b1;
            dir_d   = req_dir_q;
            tcnt_d  = '0;
          end else begin
            if (!sat) begin
              tcnt_d = tcnt_q + TW'(1);
            end
            if (calc_done) begin
              state_d = S_RUN;
            end
          end
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      tcnt_q    <= '0;
      tick_q    <= 1'b0;
      dir_q     <= DIR_RIGHT;
      req_dir_q <= DIR_RIGHT;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      tick_q    <= tick_d;
      dir_q     <= dir_d;
      req_dir_q <= req_dir_d;
    end
  end

  assign direction = dir_q;
  assign move_tick = tick_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// Directed bench for direction_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=10.
// Pause steps follow DIRECTION_PAUSE_EN as the design does.
module tb_direction_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_left;
  logic       btn_top;
  logic       btn_right;
  logic       btn_down;
  logic       btn_pause;
  logic       calc_done;
  logic [1:0] direction;
  logic       move_tick;
  logic       paused;

  int checks     = 0;
  int errors     = 0;
  int mon_checks = 0;
  int mon_errors = 0;
  int cyc        = 0;
  int cd_delay   = 2;
  int cd_cnt     = 0;
  int at;

  always #5 clk = ~clk;

  direction_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_left (btn_left),
    .btn_top  (btn_top),
    .btn_right(btn_right),
    .btn_down (btn_down),
    .btn_pause(btn_pause),
    .calc_done(calc_done),
    .direction(direction),
    .move_tick(move_tick),
    .paused   (paused)
  );

  // Edge index since reset release: edge k yields cyc == k.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // game_logic stand-in: calc_done cd_delay cycles after each tick.
  initial begin
    calc_done = 1'b0;
    forever begin
      @(negedge clk);
      calc_done = 1'b0;
      if (rst) begin
        cd_cnt = 0;
      end else begin
        if (cd_cnt > 0) begin
          cd_cnt--;
          if (cd_cnt == 0) calc_done = 1'b1;
        end
        if (move_tick) cd_cnt = cd_delay;
      end
    end
  end

  initial begin
    logic [1:0] pd;
    logic       pt;
    pd = 2'd2;
    pt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (move_tick === 1'b1) begin
          mon_checks++;
          assert (pt !== 1'b1) else begin
            mon_errors++;
            $error("FAIL double_tick observed=1 expected=0 at cyc %0d", cyc);
          end
        end
        if (direction !== pd) begin
          mon_checks++;
          assert (move_tick === 1'b1) else begin
            mon_errors++;
            $error("FAIL dir_no_tick observed=%0d expected=1 at cyc %0d",
                   move_tick, cyc);
          end
        end
      end
      pd = direction;
      pt = move_tick;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input int maxc, output int t);
    t = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (move_tick === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    btn_left  = 1'b0;
    btn_top   = 1'b0;
    btn_right = 1'b0;
    btn_down  = 1'b0;
    btn_pause = 1'b0;
    step(3);
    chk("rst_dir", 32'(direction), 2);
    chk("rst_tick", 32'(move_tick), 0);
    chk("rst_paused", 32'(paused), 0);
    rst = 1'b0;

    wait_tick(15, at);
    chk("tick10", at, 10);
    chk("dir10", 32'(direction), 2);
    wait_tick(15, at);
    chk("tick20", at, 20);
    chk("dir20", 32'(direction), 2);
    wait_tick(15, at);
    chk("tick30", at, 30);
    chk("dir30", 32'(direction), 2);

    step(2);
    btn_top = 1'b1;
    step(7);
    wait_tick(5, at);
    btn_top = 1'b0;
    chk("tick40", at, 40);
    chk("dir_top", 32'(direction), 1);

    step(2);
    btn_left = 1'b1;
    step(7);
    wait_tick(5, at);
    btn_left = 1'b0;
    chk("tick50", at, 50);
    chk("dir_left", 32'(direction), 0);

    step(2);
    btn_right = 1'b1;
    step(7);
    wait_tick(5, at);
    btn_right = 1'b0;
    chk("tick60", at, 60);
    chk("dir_opp_right", 32'(direction), 0);

    step(2);
    btn_down = 1'b1;
    step(2);
    btn_down = 1'b0;
    wait_tick(12, at);
    chk("tick70", at, 70);
    chk("dir_glitch", 32'(direction), 0);
    wait_tick(15, at);
    chk("tick80", at, 80);
    chk("dir_glitch2", 32'(direction), 0);

    step(2);
    btn_top  = 1'b1;
    btn_down = 1'b1;
    step(7);
    wait_tick(5, at);
    btn_top  = 1'b0;
    btn_down = 1'b0;
    chk("tick90", at, 90);
    chk("dir_prio", 32'(direction), 1);

    step(1);
    cd_delay = 25;
    wait_tick(15, at);
    chk("tick100", at, 100);
    chk("dir100", 32'(direction), 1);
    step(1);
    cd_delay = 2;
    step(1);
    btn_right = 1'b1;
    step(8);
    btn_right = 1'b0;
    step(2);
    btn_left = 1'b1;
    step(8);
    btn_left = 1'b0;
    wait_tick(20, at);
    chk("tick_late", at, 126);
    chk("dir_last_wins", 32'(direction), 0);
    wait_tick(15, at);
    chk("tick_resume", at, 136);

    step(1);
    btn_top = 1'b1;
    step(2);
    rst = 1'b1;
    step(3);
    chk("rst2_dir", 32'(direction), 2);
    chk("rst2_tick", 32'(move_tick), 0);
    rst = 1'b0;
    wait_tick(15, at);
    chk("rst2_tick10", at, 10);
    chk("rst2_dir_held", 32'(direction), 1);
    wait_tick(15, at);
    btn_top = 1'b0;
    chk("rst2_tick20", at, 20);

    step(1);
    btn_pause = 1'b1;
    step(6);
    btn_pause = 1'b0;
    step(2);
`ifdef DIRECTION_PAUSE_EN
    chk("paused_on", 32'(paused), 1);
    wait_tick(40, at);
    chk("no_tick_paused", at, -1);
    chk("paused_still", 32'(paused), 1);
    btn_pause = 1'b1;
    step(6);
    btn_pause = 1'b0;
    wait_tick(10, at);
    chk("tick_unpause", at, 78);
    chk("paused_off", 32'(paused), 0);
    wait_tick(15, at);
    chk("tick_after_pause", at, 88);
`else
    chk("pause_ignored", 32'(paused), 0);
    wait_tick(5, at);
    chk("tick30_nopause", at, 30);
    chk("paused_zero", 32'(paused), 0);
`endif

    chk("monitor_errors", mon_errors, 0);
    chk("monitor_active", 32'(mon_checks > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/direction_ctrl.md
DIRECTION_CTRL -- requirements
Module: direction_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: clock cycles a synchronized button level must stay stable before it is accepted.
REQ-002 Parameter TICK_CYCLES, default 12500000: clock cycles between game moves (one move per 0.5 s at 25 MHz).
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Ports btn_left, btn_top, btn_right, btn_down, input, 1 each: raw, asynchronous, active-high push-buttons.
REQ-006 Port btn_pause, input, 1: raw, asynchronous, active-high pause button.
REQ-007 Port calc_done, input, 1: is_calc_finished from game_logic.
REQ-008 Port direction, output, 2: committed move direction; LEFT=2'd0, TOP=2'd1, RIGHT=2'd2, DOWN=2'd3 (define.vh encodings).
REQ-009 Port move_tick, output, 1: single-cycle pulse that permits one game_logic step.
REQ-010 Port paused, output, 1: high while movement is frozen.

Function
REQ-011 Each button input passes through a 2-flop synchronizer before any other logic uses it.
REQ-012 A per-button counter resets on any change of the synchronized level; the debounced level takes the new value once the level has been stable for DEBOUNCE_CYCLES cycles.
REQ-013 A press event is the rising edge of a debounced level, and lasts 1 cycle.
REQ-014 Simultaneous press events resolve by priority LEFT > TOP > RIGHT > DOWN, and only one request is taken per cycle.
REQ-015 The accepted press is stored in req_dir unless it is the opposite of direction (LEFT/RIGHT, TOP/DOWN); an opposite press is discarded and leaves req_dir unchanged.
REQ-016 Any number of presses between ticks are allowed; the last press accepted under REQ-015 wins.
REQ-017 FSM states:
- RUN: tick counter increments each cycle. At TICK_CYCLES-1, the block pulses move_tick, loads direction from req_dir in the same cycle, clears the counter and enters WAIT.
- WAIT: the counter keeps incrementing but saturates at TICK_CYCLES-1. calc_done returns the FSM to RUN, keeping the counter value.
REQ-018 If the counter is saturated when calc_done arrives, move_tick fires on the next cycle. The tick interval therefore never drops below TICK_CYCLES, and no tick is lost or duplicated.
REQ-019 calc_done received while in RUN is ignored.
REQ-020 move_tick is registered and is never high on two consecutive cycles.
REQ-021 direction changes only in the cycle move_tick is asserted.
REQ-022 The tick counter width is clog2(TICK_CYCLES). Each debounce counter width is clog2(DEBOUNCE_CYCLES+1). Neither counter wraps.

Reset
REQ-023 While rst is high, the block holds direction=2'd2 (RIGHT), req_dir=2'd2, move_tick=0, paused=0, FSM=RUN, all counters=0, and all synchronizer and debounced levels=0.
REQ-024 rst asserted mid-WAIT or mid-debounce aborts the operation immediately. After release, the first move_tick occurs exactly TICK_CYCLES cycles later.
REQ-025 A button held through reset release produces a press event only after a full debounce period.

Configuration
REQ-026 Macro DIRECTION_PAUSE_EN compiles the pause feature in.
- With the macro: a btn_pause press event (debounced per REQ-012) toggles paused. While paused, the tick counter freezes, move_tick is suppressed and the FSM holds its state. Direction presses are still accepted into req_dir.
- Without the macro: btn_pause is ignored, paused is tied to 0, and no pause logic is synthesized.

Verification
REQ-027 The bench uses DEBOUNCE_CYCLES=4 and TICK_CYCLES=10, and returns calc_done 2 cycles after every move_tick.
REQ-028 Reset release with no buttons -> move_tick at cycles 10, 20, 30 after release; direction=2'd2 throughout.
REQ-029 btn_top held 8 cycles before a tick -> direction=2'd1 in the tick cycle.
REQ-030 Committed LEFT, then btn_right press -> direction remains 2'd0 after the next tick.
REQ-031 btn_down glitch high for 2 cycles -> no press event and direction unchanged.
REQ-032 calc_done withheld for 25 cycles after a tick -> next move_tick 1 cycle after calc_done, then regular 10-cycle spacing resumes.
REQ-033 With DIRECTION_PAUSE_EN: btn_pause pressed, held 40 cycles, pressed again -> no move_tick while paused=1, and the counter resumes from its frozen value.
